// File: rtl/ltc_lane_deframer.sv
// LTC two-lane DDR ADC deframer: finds and locks onto the frame
// pattern, then rebuilds 16-bit samples from lane A/B bit pairs.
module ltc_lane_deframer #(
  parameter logic [7:0]  FRAME_PATTERN = 8'hF0,
  parameter int unsigned VERIFY_FRAMES = 4,
  parameter int unsigned MISS_LIMIT    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  fr_in,
  input  logic [1:0]  a_in,
  input  logic [1:0]  b_in,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        locked,
  output logic        slip,
  output logic [15:0] err_count,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_e;

  localparam logic [3:0] VF = 4'(VERIFY_FRAMES);
  localparam logic [3:0] ML = 4'(MISS_LIMIT);

  state_e      state_q;
  logic [8:0]  fr_sr_q;
  logic [8:0]  a_sr_q;
  logic [8:0]  b_sr_q;
  logic [1:0]  phase_q;
  logic [3:0]  good_q;
  logic [3:0]  miss_q;
  logic [15:0] sample_q;
  logic [15:0] err_q;
  logic        valid_q;
  logic        locked_q;
  logic        slip_q;

  logic [7:0]  fr_w0;
  logic [7:0]  fr_w1;
  logic [7:0]  fr_w;
  logic [7:0]  a_w;
  logic [7:0]  b_w;
  logic [15:0] word_d;
  logic [15:0] err_d;
  logic [3:0]  good_d;
  logic [3:0]  miss_d;
  logic        hit0;
  logic        hit1;
  logic        fr_ok;
  logic        boundary;

  // Offset 1 drops the newest bit, so windows span sr[8:0].
  assign fr_w0 = fr_sr_q[7:0];
  assign fr_w1 = fr_sr_q[8:1];
  assign fr_w  = slip_q ? fr_w1 : fr_w0;
  assign a_w   = slip_q ? a_sr_q[8:1] : a_sr_q[7:0];
  assign b_w   = slip_q ? b_sr_q[8:1] : b_sr_q[7:0];

  assign hit0     = fr_w0 == FRAME_PATTERN;
  assign hit1     = fr_w1 == FRAME_PATTERN;
  assign fr_ok    = fr_w == FRAME_PATTERN;
  assign boundary = phase_q == 2'd3;
  assign good_d   = good_q + 4'd1;
  assign miss_d   = miss_q + 4'd1;
  assign err_d    = (err_q == 16'hFFFF) ? err_q
                                         : err_q + 16'd1;

  always_comb begin
    word_d = '0;
    for (int i = 0; i < 8; i++) begin
      word_d[2*i+1] = a_w[i];
      word_d[2*i]   = b_w[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= SEARCH;
      fr_sr_q  <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      phase_q  <= '0;
      good_q   <= '0;
      miss_q   <= '0;
      sample_q <= '0;
      err_q    <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      slip_q   <= 1'b0;
    end else begin
      fr_sr_q <= {fr_sr_q[6:0], fr_in};
      a_sr_q  <= {a_sr_q[6:0], a_in};
      b_sr_q  <= {b_sr_q[6:0], b_in};
      phase_q <= phase_q + 2'd1;
      valid_q <= 1'b0;
      if (err_clr) begin
        err_q <= '0;
      end
      unique case (state_q)
        SEARCH: begin
          if (hit0 || hit1) begin
            slip_q  <= !hit0;
            phase_q <= 2'd0;
            good_q  <= 4'd1;
            miss_q  <= 4'd0;
            if (VF == 4'd1) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end else begin
              state_q <= VERIFY;
            end
          end
        end
        VERIFY: begin
          if (boundary) begin
            if (fr_ok) begin
              good_q <= good_d;
              if (good_d == VF) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                miss_q   <= 4'd0;
              end
            end else begin
              state_q <= SEARCH;
              good_q  <= 4'd0;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            valid_q  <= 1'b1;
            sample_q <= word_d;
            if (fr_ok) begin
              miss_q <= 4'd0;
            end else begin
              if (!err_clr) begin
                err_q <= err_d;
              end
              if (miss_d == ML) begin
                state_q  <= SEARCH;
                locked_q <= 1'b0;
                miss_q   <= 4'd0;
                good_q   <= 4'd0;
              end else begin
                miss_q <= miss_d;
              end
            end
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign locked       = locked_q;
  assign slip         = slip_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_ltc_lane_deframer.sv
// Bench for ltc_lane_deframer: bit-level stream builder plus a
// frame-rule reference model working on received-bit history.
module tb_ltc_lane_deframer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        err_clr = 1'b0;
  logic [1:0]  fr_in = '0;
  logic [1:0]  a_in = '0;
  logic [1:0]  b_in = '0;
  logic [15:0] sample;
  logic [15:0] err_count;
  logic        sample_valid;
  logic        locked;
  logic        slip;

  always #5 clk = ~clk;

  ltc_lane_deframer dut (
    .clk(clk),
    .reset_n(reset_n),
    .fr_in(fr_in),
    .a_in(a_in),
    .b_in(b_in),
    .sample(sample),
    .sample_valid(sample_valid),
    .locked(locked),
    .slip(slip),
    .err_count(err_count),
    .err_clr(err_clr)
  );

  int checks = 0;
  int failures = 0;

  bit bf[$];
  bit ba[$];
  bit bb[$];
  logic [34:0] glog[$];
  logic [34:0] elog[$];

  bit hf[$];
  bit ha[$];
  bit hb[$];
  int m_st;
  int m_anchor;
  int m_good;
  int m_miss;
  int m_t;
  logic m_slip;
  logic m_valid;
  logic m_locked;
  logic [15:0] m_sample;
  logic [15:0] m_err;

  task automatic push_frame(input logic [15:0] s, input logic [7:0] f);
    for (int i = 7; i >= 0; i--) begin
      bf.push_back(f[i]);
      ba.push_back(s[2*i+1]);
      bb.push_back(s[2*i]);
    end
  endtask

  task automatic push_lead();
    bf.push_back(1'b0);
    ba.push_back(1'b0);
    bb.push_back(1'b0);
  endtask

  // Last 8 received bits, skipping the k newest.
  function automatic logic [7:0] win(input bit h[$], input int k);
    logic [7:0] v;
    int n;
    v = '0;
    n = h.size();
    for (int i = 0; i < 8; i++) begin
      if (n - 1 - k - i >= 0) v[i] = h[n-1-k-i];
    end
    return v;
  endfunction

  task automatic keep9();
    while (hf.size() > 9) begin
      void'(hf.pop_front());
      void'(ha.pop_front());
      void'(hb.pop_front());
    end
  endtask

  task automatic model_step(input bit rst, input bit clr,
                            input logic [1:0] f,
                            input logic [1:0] a,
                            input logic [1:0] b);
    logic [7:0] w0;
    logic [7:0] w1;
    logic [7:0] fw;
    logic [7:0] aw;
    logic [7:0] bw;
    bit edge4;
    if (!rst) begin
      hf.delete(); ha.delete(); hb.delete();
      m_st = 0; m_slip = 0; m_valid = 0; m_locked = 0;
      m_sample = '0; m_err = '0; m_good = 0; m_miss = 0;
      m_t = 0; m_anchor = 0;
      return;
    end
    m_t++;
    w0 = win(hf, 0);
    w1 = win(hf, 1);
    fw = m_slip ? w1 : w0;
    aw = win(ha, int'(m_slip));
    bw = win(hb, int'(m_slip));
    edge4 = ((m_t - m_anchor) % 4) == 0;
    m_valid = 0;
    if (m_st == 0) begin
      if (w0 == 8'hF0 || w1 == 8'hF0) begin
        m_slip = (w0 != 8'hF0);
        m_anchor = m_t;
        m_good = 1;
        m_st = 1;
      end
    end else if (edge4) begin
      if (m_st == 1) begin
        if (fw == 8'hF0) begin
          m_good++;
          if (m_good == 4) begin
            m_st = 2; m_locked = 1; m_miss = 0;
          end
        end else begin
          m_st = 0; m_good = 0;
        end
      end else begin
        m_valid = 1;
        for (int i = 0; i < 8; i++) begin
          m_sample[2*i+1] = aw[i];
          m_sample[2*i] = bw[i];
        end
        if (fw == 8'hF0) begin
          m_miss = 0;
        end else begin
          if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
          m_miss++;
          if (m_miss == 3) begin
            m_st = 0; m_locked = 0; m_miss = 0; m_good = 0;
          end
        end
      end
    end
    if (clr) m_err = '0;
    hf.push_back(f[1]); hf.push_back(f[0]);
    ha.push_back(a[1]); ha.push_back(a[0]);
    hb.push_back(b[1]); hb.push_back(b[0]);
    keep9();
  endtask

  // Two reset cycles, then one bit pair per cycle; log index = cycle.
  task automatic run(input int rst_at, input int clr_at);
    int n;
    int j;
    logic [1:0] f;
    logic [1:0] a;
    logic [1:0] b;
    bit r;
    bit cl;
    if (bf.size() % 2 != 0) push_lead();
    n = bf.size() / 2;
    glog.delete();
    elog.delete();
    for (int c = 0; c < n + 2; c++) begin
      j = c - 2;
      f = '0; a = '0; b = '0;
      r = (c >= 2) && (j != rst_at);
      cl = (c >= 2) && (j == clr_at);
      if (c >= 2) begin
        f = {bf[2*j], bf[2*j+1]};
        a = {ba[2*j], ba[2*j+1]};
        b = {bb[2*j], bb[2*j+1]};
      end
      @(negedge clk);
      fr_in = f; a_in = a; b_in = b;
      reset_n = r; err_clr = cl;
      @(posedge clk);
      model_step(r, cl, f, a, b);
      #1;
      glog.push_back({sample_valid, locked, slip, err_count, sample});
      elog.push_back({m_valid, m_locked, m_slip, m_err, m_sample});
    end
    bf.delete(); ba.delete(); bb.delete();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) push_frame(16'h1234, 8'hF0);
    run(-1, -1);
    checks++;
    if (glog[1] !== 35'd0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", glog[1]);
    end
    for (int c = 0; c < glog.size(); c++) begin
      checks++;
      if (glog[c] !== elog[c]) begin
        failures++;
        $display("FAIL reset_trace cyc=%0d got=%h exp=%h", c, glog[c], elog[c]);
      end
    end
  endtask

  task automatic test_align0();
    for (int i = 0; i < 10; i++) push_frame(16'h000D, 8'hF0);
    run(-1, -1);
    checks++;
    if (glog[17][33] !== 1'b0 || glog[18][33] !== 1'b1) begin
      failures++;
      $display("FAIL a0_lock_time got=%b%b exp=01", glog[17][33], glog[18][33]);
    end
    checks++;
    if (glog[22][15:0] !== 16'h000D || glog[22][32] !== 1'b0) begin
      failures++;
      $display("FAIL a0_sample got=%h slip=%b exp=000d slip=0", glog[22][15:0], glog[22][32]);
    end
    for (int c = 19; c < glog.size(); c++) begin
      checks++;
      if (glog[c][34] !== (((c - 18) % 4) == 0)) begin
        failures++;
        $display("FAIL a0_cadence cyc=%0d got=%b", c, glog[c][34]);
      end
    end
    checks++;
    if (glog[glog.size()-1][31:16] !== 16'd0) begin
      failures++;
      $display("FAIL a0_err got=%h exp=0", glog[glog.size()-1][31:16]);
    end
  endtask

  task automatic test_align1(input logic [15:0] s);
    push_lead();
    for (int i = 0; i < 10; i++) push_frame(s, 8'hF0);
    run(-1, -1);
    checks++;
    if (glog[18][33] !== 1'b0 || glog[19][33] !== 1'b1) begin
      failures++;
      $display("FAIL a1_lock_time got=%b%b exp=01", glog[18][33], glog[19][33]);
    end
    checks++;
    if (glog[23] !== {3'b111, 16'd0, s}) begin
      failures++;
      $display("FAIL a1_sample got=%h exp=%h", glog[23], {3'b111, 16'd0, s});
    end
    for (int c = 0; c < glog.size(); c++) begin
      checks++;
      if (glog[c] !== elog[c]) begin
        failures++;
        $display("FAIL a1_trace cyc=%0d got=%h exp=%h", c, glog[c], elog[c]);
      end
    end
  endtask

  task automatic test_single_error();
    for (int i = 0; i < 10; i++)
      push_frame(16'($urandom), (i == 6) ? 8'hF1 : 8'hF0);
    run(-1, -1);
    checks++;
    if (glog[30] !== {3'b110, 16'd1, glog[30][15:0]}) begin
      failures++;
      $display("FAIL err1_boundary got=%h exp err=1 valid locked", glog[30]);
    end
    checks++;
    if (glog[34][34:33] !== 2'b11 || glog[41][31:16] !== 16'd1) begin
      failures++;
      $display("FAIL err1_after got=%h/%h exp valid locked err=1", glog[34], glog[41]);
    end
    for (int c = 0; c < glog.size(); c++) begin
      checks++;
      if (glog[c] !== elog[c]) begin
        failures++;
        $display("FAIL err1_trace cyc=%0d got=%h exp=%h", c, glog[c], elog[c]);
      end
    end
  endtask

  task automatic test_lock_loss();
    for (int i = 0; i < 14; i++)
      push_frame(16'($urandom), (i >= 5 && i <= 7) ? 8'hF1 : 8'hF0);
    run(-1, -1);
    checks++;
    if (glog[30][33] !== 1'b1 || glog[34][33] !== 1'b0) begin
      failures++;
      $display("FAIL loss_drop got=%b%b exp=10", glog[30][33], glog[34][33]);
    end
    checks++;
    if (glog[34][31:16] !== 16'd3) begin
      failures++;
      $display("FAIL loss_err got=%h exp=3", glog[34][31:16]);
    end
    checks++;
    if (glog[49][33] !== 1'b0 || glog[50][33] !== 1'b1) begin
      failures++;
      $display("FAIL loss_relock got=%b%b exp=01", glog[49][33], glog[50][33]);
    end
    for (int c = 0; c < glog.size(); c++) begin
      checks++;
      if (glog[c] !== elog[c]) begin
        failures++;
        $display("FAIL loss_trace cyc=%0d got=%h exp=%h", c, glog[c], elog[c]);
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 14; i++) push_frame(16'hA5C3, 8'hF0);
    run(30, -1);
    checks++;
    if (glog[31][33] !== 1'b1 || glog[32] !== 35'd0) begin
      failures++;
      $display("FAIL mrst_clear got=%h exp=0", glog[32]);
    end
    checks++;
    if (glog[49][33] !== 1'b0 || glog[50][33] !== 1'b1) begin
      failures++;
      $display("FAIL mrst_relock got=%b%b exp=01", glog[49][33], glog[50][33]);
    end
    for (int c = 0; c < glog.size(); c++) begin
      checks++;
      if (glog[c] !== elog[c]) begin
        failures++;
        $display("FAIL mrst_trace cyc=%0d got=%h exp=%h", c, glog[c], elog[c]);
      end
    end
  endtask

  task automatic test_err_clr();
    for (int i = 0; i < 12; i++)
      push_frame(16'($urandom), (i == 6 || i == 8) ? 8'hF1 : 8'hF0);
    run(-1, 36);
    checks++;
    if (glog[30][31:16] !== 16'd1) begin
      failures++;
      $display("FAIL clr_pre got=%h exp=1", glog[30][31:16]);
    end
    checks++;
    if (glog[38][31:16] !== 16'd0 || glog[38][34:33] !== 2'b11) begin
      failures++;
      $display("FAIL clr_prio got=%h exp err=0 valid locked", glog[38]);
    end
    for (int c = 0; c < glog.size(); c++) begin
      checks++;
      if (glog[c] !== elog[c]) begin
        failures++;
        $display("FAIL clr_trace cyc=%0d got=%h exp=%h", c, glog[c], elog[c]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] f;
    for (int it = 0; it < 4; it++) begin
      if ($urandom_range(0, 1) == 1) push_lead();
      for (int i = 0; i < 24; i++) begin
        f = 8'hF0;
        if (i > 4 && $urandom_range(0, 4) == 0)
          f = 8'hF0 ^ 8'($urandom_range(1, 255));
        push_frame(16'($urandom), f);
      end
      run(-1, int'($urandom_range(20, 90)));
      for (int c = 0; c < glog.size(); c++) begin
        checks++;
        if (glog[c] !== elog[c]) begin
          failures++;
          $display("FAIL rnd_trace it=%0d cyc=%0d got=%h exp=%h", it, c, glog[c], elog[c]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_align0();
    test_align1(16'h000D);
    test_align1(16'hE002);
    test_single_error();
    test_lock_loss();
    test_mid_reset();
    test_err_clr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
